// File: rtl/lsu_align_unit.sv
// lsu_align_unit: MEM-stage load/store engine (lane alignment, load extension, stall); LSU_MISALIGN_TRAP_EN enables misalignment faults.
// Latency: store 2 / load >=3 cycles after accept, fault 1; waits on mem_gnt/mem_rvalid with lsu_stall held high.
module lsu_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              lsu_stall,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [OFF-1:0]    off_q;
    logic [4:0]        rd_q;
    logic              stall_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [NB-1:0]     mem_wstrb_q;
    logic [XLEN-1:0]   mem_wdata_q;

    logic              resp_valid_q;
    logic              resp_err_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic [4:0]        resp_rd_q;

    logic [1:0]        in_size;
    logic [OFF-1:0]    in_off_raw;
    logic [OFF-1:0]    in_lowmask;
    logic [OFF-1:0]    in_off;
    logic              in_fault;
    logic [NB-1:0]     in_strb;
    logic [XLEN-1:0]   in_wdata;
    logic [ADDR_W-1:0] in_addr;

    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_data;
    logic              ld_sign;
    int                ld_nbits;

    // Doubleword requests on a 32-bit datapath degrade to word accesses.
    always_comb begin
        in_size = req_funct3[1:0];
        if (XLEN == 32 && in_size == 2'd3) begin
            in_size = 2'd2;
        end
    end

    always_comb begin
        case (in_size)
            2'd0:    in_lowmask = OFF'(0);
            2'd1:    in_lowmask = OFF'(1);
            2'd2:    in_lowmask = OFF'(3);
            default: in_lowmask = OFF'(7);
        endcase
    end

    assign in_off_raw = req_addr[OFF-1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign in_off   = in_off_raw;
    assign in_fault = |(in_off_raw & in_lowmask);
`else
    assign in_off   = in_off_raw & ~in_lowmask;
    assign in_fault = 1'b0;
`endif

    assign in_addr  = {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign in_wdata = req_wdata << {in_off, 3'b000};

    always_comb begin
        in_strb = '0;
        for (int i = 0; i < NB; i++) begin
            in_strb[i] = req_we && (i >= int'(in_off)) && (i < int'(in_off) + (1 << in_size));
        end
    end

    // Load path: bring the addressed lane down to bit 0, then extend above the access width.
    assign ld_shift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    begin ld_nbits = 8;    ld_sign = ld_shift[7];      end
            2'd1:    begin ld_nbits = 16;   ld_sign = ld_shift[15];     end
            2'd2:    begin ld_nbits = 32;   ld_sign = ld_shift[31];     end
            default: begin ld_nbits = XLEN; ld_sign = ld_shift[XLEN-1]; end
        endcase
        ld_sign = ld_sign & ~uns_q;
        ld_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            ld_data[i] = (i < ld_nbits) ? ld_shift[i] : ld_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            rd_q         <= '0;
            stall_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q   <= req_we;
                        size_q <= in_size;
                        uns_q  <= req_funct3[2];
                        off_q  <= in_off;
                        rd_q   <= req_rd;
                        if (in_fault) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_rd_q    <= req_rd;
                        end else begin
                            state_q     <= ISSUE;
                            stall_q     <= 1'b1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= in_addr;
                            mem_wstrb_q <= in_strb;
                            mem_wdata_q <= in_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (we_q) begin
                            state_q      <= RESP;
                            stall_q      <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= '0;
                            resp_rd_q    <= rd_q;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q      <= RESP;
                        stall_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= ld_data;
                        resp_rd_q    <= rd_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign lsu_stall  = ((state_q == IDLE) && req_valid) || stall_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench for lsu_align_unit: 32-bit instance for lane/extension/handshake/reset cases, 64-bit instance for D/WU lanes.
module tb_lsu_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-bit instance
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        lsu_stall, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    lsu_align_unit #(.XLEN(32), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .lsu_stall(lsu_stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // 64-bit instance
    logic        p_req_valid, p_req_ready, p_req_we;
    logic [2:0]  p_req_funct3;
    logic [31:0] p_req_addr;
    logic [63:0] p_req_wdata;
    logic [4:0]  p_req_rd;
    logic        p_lsu_stall, p_resp_valid, p_resp_err;
    logic [63:0] p_resp_rdata;
    logic [4:0]  p_resp_rd;
    logic        p_mem_req, p_mem_we, p_mem_gnt, p_mem_rvalid;
    logic [31:0] p_mem_addr;
    logic [63:0] p_mem_wdata, p_mem_rdata;
    logic [7:0]  p_mem_wstrb;

    lsu_align_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(p_req_valid), .req_ready(p_req_ready), .req_we(p_req_we),
        .req_funct3(p_req_funct3), .req_addr(p_req_addr), .req_wdata(p_req_wdata), .req_rd(p_req_rd),
        .lsu_stall(p_lsu_stall),
        .resp_valid(p_resp_valid), .resp_rdata(p_resp_rdata), .resp_rd(p_resp_rd), .resp_err(p_resp_err),
        .mem_req(p_mem_req), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wstrb(p_mem_wstrb),
        .mem_wdata(p_mem_wdata), .mem_gnt(p_mem_gnt), .mem_rvalid(p_mem_rvalid), .mem_rdata(p_mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [63:0] rdata;
        int          cyc;
    } exp64_t;

    exp_t   sb[$];
    exp64_t sb64[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference load extraction, written byte-by-byte.
    function automatic logic [31:0] ld_model(input logic [31:0] raw, input int off, input int bytes, input logic uns);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < bytes; b++) v[8*b +: 8] = raw[8*(off+b) +: 8];
        if (!uns && v[8*bytes-1]) v = v | ~((64'd1 << (8*bytes)) - 64'd1);
        return v[31:0];
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", {63'd0, resp_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
                    chk("resp_rd", {59'd0, resp_rd}, {59'd0, e.rd});
                    chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && p_resp_valid) begin
                if (sb64.size() == 0) begin
                    chk("resp64_unexpected", {63'd0, p_resp_valid}, 64'd0);
                end else begin
                    exp64_t e;
                    e = sb64.pop_front();
                    chk("resp64_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp64_rdata", p_resp_rdata, e.rdata);
                    chk("resp64_rd", {59'd0, p_resp_rd}, 64'd5);
                    chk("resp64_err", {63'd0, p_resp_err}, 64'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // Called and returns at a negedge. gd = cycles gnt is withheld, rdly = cycles rvalid is withheld.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata, input int gd, input int rdly,
                          input logic [31:0] e_addr, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata, input logic e_fault);
        int   a;
        int   guard;
        exp_t e;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("ready_timeout", {63'd0, req_ready}, 64'd1);
        a = cyc;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        e.rdata = e_rdata; e.rd = rd; e.err = e_fault;
        e.cyc = e_fault ? a + 1 : (we ? a + 2 + gd : a + 3 + gd + rdly);
        sb.push_back(e);
        #1 chk("stall_req", {63'd0, lsu_stall}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        if (e_fault) begin
            #1;
            chk("fault_no_req", {63'd0, mem_req}, 64'd0);
            chk("fault_stall", {63'd0, lsu_stall}, 64'd0);
            @(negedge clk);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            if (i == gd) begin
                mem_gnt = 1'b1; mem_rvalid = 1'b0;
            end else if (!we) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
            end
            #1;
            chk("mem_req", {63'd0, mem_req}, 64'd1);
            chk("mem_we", {63'd0, mem_we}, {63'd0, we});
            chk("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
            chk("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, e_strb});
            if (we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wdata});
            chk("stall_issue", {63'd0, lsu_stall}, 64'd1);
            @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!we) begin
            for (int j = 0; j <= rdly; j++) begin
                if (j == rdly) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata;
                end
                #1;
                chk("stall_wait", {63'd0, lsu_stall}, 64'd1);
                chk("req_dropped", {63'd0, mem_req}, 64'd0);
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
        end
        #1;
        chk("stall_resp", {63'd0, lsu_stall}, 64'd0);
        chk("ready_resp", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
    endtask

    task automatic acc64(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input logic [31:0] e_addr, input logic [7:0] e_strb,
                         input logic [63:0] e_wdata, input logic [63:0] e_rdata);
        int     a;
        exp64_t e;
        chk("ready64", {63'd0, p_req_ready}, 64'd1);
        a = cyc;
        p_req_valid = 1'b1; p_req_we = we; p_req_funct3 = f3; p_req_addr = addr; p_req_wdata = wdata;
        e.rdata = e_rdata; e.cyc = we ? a + 2 : a + 3;
        sb64.push_back(e);
        @(negedge clk);
        p_req_valid = 1'b0; p_mem_gnt = 1'b1;
        #1;
        chk("mem64_req", {63'd0, p_mem_req}, 64'd1);
        chk("mem64_addr", {32'd0, p_mem_addr}, {32'd0, e_addr});
        chk("mem64_wstrb", {56'd0, p_mem_wstrb}, {56'd0, e_strb});
        if (we) chk("mem64_wdata", p_mem_wdata, e_wdata);
        @(negedge clk);
        p_mem_gnt = 1'b0;
        if (!we) begin
            p_mem_rvalid = 1'b1; p_mem_rdata = rdata;
            @(negedge clk);
            p_mem_rvalid = 1'b0;
        end
        #1 chk("stall64_resp", {63'd0, p_lsu_stall}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        p_req_valid = 0; p_req_we = 0; p_req_funct3 = 0; p_req_addr = 0; p_req_wdata = 0; p_req_rd = 5'd5;
        p_mem_gnt = 0; p_mem_rvalid = 0; p_mem_rdata = 0;
        repeat (3) @(negedge clk);

        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        chk("rst_stall", {63'd0, lsu_stall}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wstrb", {60'd0, mem_wstrb}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
        chk("rst_resp_rd", {59'd0, resp_rd}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Lane placement for stores and extension for loads
        access(1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 0, 0, 0, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0);
        access(1, 3'b000, 32'h103, 32'h000000A5, 5'd2, 0, 0, 0, 32'h100, 4'h8, 32'hA5000000, 0, 0);
        access(1, 3'b001, 32'h102, 32'h00001234, 5'd3, 0, 0, 0, 32'h100, 4'hC, 32'h12340000, 0, 0);
        access(0, 3'b001, 32'h102, 0, 5'd7, 32'h80011111, 0, 0, 32'h100, 4'h0, 0, 32'hFFFF8001, 0);
        access(0, 3'b101, 32'h102, 0, 5'd9, 32'h80011111, 0, 0, 32'h100, 4'h0, 0, 32'h00008001, 0);
        access(0, 3'b000, 32'h203, 0, 5'd4, 32'h7F000000, 0, 0, 32'h200, 4'h0, 0, 32'h0000007F, 0);
        access(1, 3'b011, 32'h304, 32'h55AA55AA, 5'd6, 0, 0, 0, 32'h304, 4'hF, 32'h55AA55AA, 0, 0);

        // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
        access(0, 3'b010, 32'h101, 0, 5'd11, 32'h11223344, 0, 0, 32'h100, 4'h0, 0, 32'h0, 1'b1);
`else
        access(0, 3'b010, 32'h101, 0, 5'd11, 32'h11223344, 0, 0, 32'h100, 4'h0, 0, 32'h11223344, 1'b0);
`endif

        // Withheld gnt (with stray rvalid during ISSUE) and delayed rvalid
        access(1, 3'b010, 32'h200, 32'hCAFEF00D, 5'd12, 0, 3, 0, 32'h200, 4'hF, 32'hCAFEF00D, 0, 0);
        access(0, 3'b000, 32'h201, 0, 5'd13, 32'h0000F000, 3, 2, 32'h200, 4'h0, 0, 32'hFFFFFFF0, 0);

        // Reset while waiting for load data: request is dropped silently
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd14;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        #1 chk("rstw_issue", {63'd0, mem_req}, 64'd1);
        @(negedge clk);
        mem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rstw_ready", {63'd0, req_ready}, 64'd1);
        chk("rstw_stall", {63'd0, lsu_stall}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1 chk("stray_rvalid_resp", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        chk("stray_rvalid_ready", {63'd0, req_ready}, 64'd1);

        // Randomised aligned accesses against the byte-wise model
        for (int n = 0; n < 16; n++) begin
            logic        we;
            logic        uns;
            logic [1:0]  s;
            int          bytes;
            int          off;
            logic [31:0] addr, wd, rdt;
            we    = 1'($urandom_range(0, 1));
            s     = 2'($urandom_range(0, 3));
            bytes = (s == 2'd3) ? 4 : (1 << s);
            off   = int'($urandom_range(0, 3)) & ~(bytes - 1);
            uns   = we ? 1'b0 : 1'($urandom_range(0, 1));
            addr  = ($urandom() & 32'hFFFF_FFFC) | 32'(off);
            wd    = $urandom();
            rdt   = $urandom();
            access(we, {uns, s}, addr, wd, 5'(n + 16), rdt, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   addr & ~32'h3, we ? 4'(((1 << bytes) - 1) << off) : 4'h0, wd << (8 * off),
                   we ? 32'h0 : ld_model(rdt, off, bytes, uns), 1'b0);
        end

        // 64-bit datapath
        acc64(0, 3'b110, 32'h104, 0, 64'h89ABCDEF_00000000, 32'h100, 8'h00, 0, 64'h00000000_89ABCDEF);
        acc64(0, 3'b010, 32'h104, 0, 64'h89ABCDEF_00000000, 32'h100, 8'h00, 0, 64'hFFFFFFFF_89ABCDEF);
        acc64(0, 3'b011, 32'h100, 0, 64'h01234567_89ABCDEF, 32'h100, 8'h00, 0, 64'h01234567_89ABCDEF);
        acc64(1, 3'b011, 32'h108, 64'h01234567_89ABCDEF, 0, 32'h108, 8'hFF, 64'h01234567_89ABCDEF, 0);
        acc64(1, 3'b010, 32'h10C, 64'h00000000_CAFEF00D, 0, 32'h108, 8'hF0, 64'hCAFEF00D_00000000, 0);
        acc64(1, 3'b000, 32'h10D, 64'h00000000_000000EE, 0, 32'h108, 8'h20, 64'h0000EE00_00000000, 0);

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("sb64_drained", 64'(sb64.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
